// File: rtl/i2c_xfer_sequencer_if.sv
// Bus port between the transaction sequencer and the memory-mapped I2C IO block.
// The sequencer is the master; the IO block (or its model) is the slave.
interface i2c_xfer_sequencer_if;
  logic        bus_cs;
  logic        bus_read;
  logic        bus_write;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_cs, bus_read, bus_write, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_cs, bus_read, bus_write, bus_addr, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// Register-level I2C transaction engine: turns one register read/write request
// into the START/address/register/data/STOP command sequence on the IO block bus.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | waiting for req; request fields latched on acceptance
// S_SET_FREQ | one-cycle write of the SCL divider (addr 0)
// S_ISSUE    | one-cycle write of the current step's command (addr 1)
// S_HOLD     | HOLD idle cycles so the IO block can drop rdy
// S_POLL     | reading addr 1 until rdy; ACK check, data capture, step advance
// S_DONE     | one-cycle done pulse, then back to idle
module i2c_xfer_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int HOLD    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_i,
  input  logic                        rnw_i,
  input  logic [6:0]                  dev_addr_i,
  input  logic [7:0]                  reg_addr_i,
  input  logic [7:0]                  wdata_i,
  input  logic [1:0]                  freq_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [1:0]                  err_code_o,
  output logic [7:0]                  rdata_o,
  i2c_xfer_sequencer_if.master        bus
);

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_NACK_DEV = 2'd1;
  localparam logic [1:0] ERR_NACK_DAT = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // One down-counter serves both the HOLD wait and the poll timeout.
  localparam int CNT_MAX = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_FREQ,
    S_ISSUE,
    S_HOLD,
    S_POLL,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [4:0]      bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;

  logic            rnw_q;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q;
  logic [7:0]      wbyte_q;
  logic [1:0]      freq_q;

  logic            cs_strobe, rd_strobe, wr_strobe;
  logic            accept;
  logic [10:0]     cur_cmd;
  logic [2:0]      cur_op;
  logic [2:0]      stop_step;
  logic            is_addr_step;
  logic            rdy, ack;
  logic [7:0]      dout;
  logic            unused_rdata_bits;

  // Command word {op, din} for each step of the write or read sequence.
  function automatic logic [10:0] step_cmd(
    input logic [2:0] step,
    input logic       rnw,
    input logic [6:0] dev,
    input logic [7:0] ra,
    input logic [7:0] wb
  );
    logic [10:0] c;
    case (step)
      3'd0:    c = {CMD_START, 8'h00};
      3'd1:    c = {CMD_WR, dev, 1'b0};
      3'd2:    c = {CMD_WR, ra};
      3'd3:    c = rnw ? {CMD_RESTART, 8'h00} : {CMD_WR, wb};
      3'd4:    c = rnw ? {CMD_WR, dev, 1'b1} : {CMD_STOP, 8'h00};
      3'd5:    c = {CMD_RD, 8'h01};
      default: c = {CMD_STOP, 8'h00};
    endcase
    return c;
  endfunction

  assign rdy  = bus.bus_rdata[8];
  assign ack  = bus.bus_rdata[9];
  assign dout = bus.bus_rdata[7:0];
  assign unused_rdata_bits = ^bus.bus_rdata[31:10];

  assign accept       = (state_q == S_IDLE) && req_i;
  assign cur_cmd      = step_cmd(step_q, rnw_q, dev_q, reg_q, wbyte_q);
  assign cur_op       = cur_cmd[10:8];
  assign stop_step    = rnw_q ? 3'd6 : 3'd4;
  assign is_addr_step = (step_q == 3'd1) || (rnw_q && (step_q == 3'd4));

  // Next-state, strobe and status logic for the command sequencer.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cs_strobe   = 1'b0;
    rd_strobe   = 1'b0;
    wr_strobe   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = S_SET_FREQ;
          step_d  = 3'd0;
          err_d   = ERR_OK;
        end
      end

      S_SET_FREQ: begin
        cs_strobe   = 1'b1;
        wr_strobe   = 1'b1;
        bus_addr_d  = 5'd0;
        bus_wdata_d = {30'd0, freq_q};
        state_d     = S_ISSUE;
      end

      S_ISSUE: begin
        cs_strobe   = 1'b1;
        wr_strobe   = 1'b1;
        bus_addr_d  = 5'd1;
        bus_wdata_d = {21'd0, cur_cmd};
        cnt_d       = CW'(HOLD - 1);
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(TIMEOUT - 1);
          state_d = S_POLL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_POLL: begin
        cs_strobe  = 1'b1;
        rd_strobe  = 1'b1;
        bus_addr_d = 5'd1;
        if (rdy) begin
          if ((cur_op == CMD_WR) && ack) begin
            err_d   = is_addr_step ? ERR_NACK_DEV : ERR_NACK_DAT;
            step_d  = stop_step;
            state_d = S_ISSUE;
          end else if (cur_op == CMD_STOP) begin
            state_d = S_DONE;
          end else begin
            if (cur_op == CMD_RD) begin
              rdata_d = dout;
            end
            step_d  = step_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else if (cnt_q == '0) begin
          // Abandon the transfer without STOP: the IO block is not answering.
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, status and held bus address/data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      cnt_q       <= '0;
      err_q       <= ERR_OK;
      rdata_q     <= 8'h00;
      bus_addr_q  <= 5'd0;
      bus_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Request fields are captured once on acceptance so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnw_q   <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      wbyte_q <= 8'd0;
      freq_q  <= 2'd0;
    end else if (accept) begin
      rnw_q   <= rnw_i;
      dev_q   <= dev_addr_i;
      reg_q   <= reg_addr_i;
      wbyte_q <= wdata_i;
      freq_q  <= freq_i;
    end
  end

  assign bus.bus_cs    = cs_strobe;
  assign bus.bus_read  = rd_strobe;
  assign bus.bus_write = wr_strobe;
  assign bus.bus_addr  = bus_addr_d;
  assign bus.bus_wdata = bus_wdata_d;

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign err_code_o = err_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench: a behavioural IO-block model answers commands, a planner
// derives the expected command stream and completion from each request, and a
// monitor compares every bus write and done pulse against the queued expectations.
module tb_i2c_xfer_sequencer;
  localparam int TO = 16;
  localparam int HD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, rnw;
  logic [6:0] dev;
  logic [7:0] ra, wd;
  logic [1:0] freq;
  logic       busy, done;
  logic [1:0] err;
  logic [7:0] rdata;

  i2c_xfer_sequencer_if bus_if();

  i2c_xfer_sequencer #(.TIMEOUT(TO), .HOLD(HD)) dut (
    .clk(clk), .rst(rst), .req_i(req), .rnw_i(rnw), .dev_addr_i(dev),
    .reg_addr_i(ra), .wdata_i(wd), .freq_i(freq), .busy_o(busy), .done_o(done),
    .err_code_o(err), .rdata_o(rdata), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_bus[$];
  logic [9:0]  exp_done[$];
  logic [7:0]  m_rdata = 8'h00;

  int         nack_idx = -1;
  int         stall_idx = -1;
  logic [7:0] rd_dout = 8'h00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // IO block model: drops rdy on each command, raises it after a random delay
  // (never if this command is the stall point), NACKs the chosen WR byte.
  int         cmd_idx, wr_idx, wait_cnt;
  logic       m_rdy, m_ack, m_stall;
  logic [7:0] m_dout;
  assign bus_if.bus_rdata = {22'd0, m_ack, m_rdy, m_dout};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_idx <= 0; wr_idx <= 0; wait_cnt <= 0;
      m_rdy <= 1'b0; m_ack <= 1'b0; m_stall <= 1'b0; m_dout <= 8'h00;
    end else if (bus_if.bus_cs && bus_if.bus_write) begin
      if (bus_if.bus_addr == 5'd0) begin
        cmd_idx <= 0;
        wr_idx  <= 0;
      end else begin
        m_rdy    <= 1'b0;
        m_stall  <= (cmd_idx == stall_idx);
        wait_cnt <= int'($urandom_range(0, 5));
        cmd_idx  <= cmd_idx + 1;
        if (bus_if.bus_wdata[10:8] == 3'd1) begin
          m_ack  <= (wr_idx == nack_idx);
          wr_idx <= wr_idx + 1;
          m_dout <= 8'($urandom);
        end else begin
          m_ack  <= 1'($urandom);
          m_dout <= (bus_if.bus_wdata[10:8] == 3'd2) ? rd_dout : 8'($urandom);
        end
      end
    end else if (!m_rdy && !m_stall) begin
      if (wait_cnt == 0) m_rdy <= 1'b1;
      else wait_cnt <= wait_cnt - 1;
    end
  end

  // Expected command stream and completion for one request.
  task automatic plan(input logic r, input logic [6:0] d, input logic [7:0] ra_,
                      input logic [7:0] wd_, input logic [1:0] f, input int nk,
                      input int st, input logic [7:0] dout);
    logic [10:0] seq[$];
    logic [1:0]  e;
    int i, k, w;
    if (r) seq = '{11'h000, {3'd1, d, 1'b0}, {3'd1, ra_}, 11'h400, {3'd1, d, 1'b1}, 11'h201, 11'h300};
    else   seq = '{11'h000, {3'd1, d, 1'b0}, {3'd1, ra_}, {3'd1, wd_}, 11'h300};
    exp_bus.push_back({5'd0, 30'd0, f});
    e = 2'd0; i = 0; k = 0; w = 0;
    while (i < seq.size()) begin
      exp_bus.push_back({5'd1, 21'd0, seq[i]});
      if (k == st) begin e = 2'd3; break; end
      k++;
      if (seq[i][10:8] == 3'd1) begin
        if (w == nk) begin
          e = (i == 1 || (r && i == 4)) ? 2'd1 : 2'd2;
          w++;
          i = seq.size() - 1;
          continue;
        end
        w++;
      end
      if (seq[i][10:8] == 3'd2) m_rdata = dout;
      i++;
    end
    exp_done.push_back({e, m_rdata});
  endtask

  // Monitor: compare each bus write and done pulse; track HOLD gap and poll counts.
  int   polls = 0, since_cmd = 0;
  logic prev_poll = 1'b0, prev_rdy = 1'b0;
  logic [36:0] eb;
  logic [9:0]  ed;
  always @(negedge clk) begin
    if (!rst) begin
      since_cmd++;
      if (bus_if.bus_cs && bus_if.bus_write) begin
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bus_write: got %0h expected none", {bus_if.bus_addr, bus_if.bus_wdata});
        end else begin
          eb = exp_bus.pop_front();
          chk("bus_write", {27'd0, bus_if.bus_addr, bus_if.bus_wdata}, {27'd0, eb});
        end
        if (bus_if.bus_addr == 5'd1) begin polls = 0; since_cmd = 0; end
      end
      if (bus_if.bus_cs && bus_if.bus_read) begin
        polls++;
        if (polls == 1) chk("hold_gap", since_cmd, HD + 1);
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got err %0d expected no done", err);
        end else begin
          ed = exp_done.pop_front();
          chk("done_status", {err, rdata}, ed);
          chk("done_after_poll", prev_poll, 1'b1);
          if (ed[9:8] == 2'd3) begin
            chk("timeout_polls", polls, TO);
            chk("timeout_no_rdy", prev_rdy, 1'b0);
          end else begin
            chk("done_after_rdy", prev_rdy, 1'b1);
          end
        end
      end
      prev_poll = bus_if.bus_cs && bus_if.bus_read;
      prev_rdy  = prev_poll && bus_if.bus_rdata[8];
    end else begin
      polls = 0; since_cmd = 0; prev_poll = 1'b0; prev_rdy = 1'b0;
    end
  end

  task automatic scramble();
    rnw = 1'($urandom); dev = 7'($urandom); ra = 8'($urandom);
    wd = 8'($urandom); freq = 2'($urandom);
  endtask

  task automatic start_req(input logic r, input logic [6:0] d, input logic [7:0] ra_,
                           input logic [7:0] wd_, input logic [1:0] f);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    req = 1'b1; rnw = r; dev = d; ra = ra_; wd = wd_; freq = f;
    @(negedge clk);
    req = 1'b0;
    scramble();
  endtask

  task automatic xfer(input logic r, input logic [6:0] d, input logic [7:0] ra_,
                      input logic [7:0] wd_, input logic [1:0] f, input int nk,
                      input int st, input logic [7:0] dout, input bit mid);
    int n;
    nack_idx = nk; stall_idx = st; rd_dout = dout;
    plan(r, d, ra_, wd_, f, nk, st, dout);
    start_req(r, d, ra_, wd_, f);
    chk("busy_rise", busy, 1'b1);
    chk("setfreq_strobe", {bus_if.bus_cs, bus_if.bus_write, bus_if.bus_read, bus_if.bus_addr}, {3'b110, 5'd0});
    @(negedge clk);
    chk("issue_strobe", {bus_if.bus_cs, bus_if.bus_write, bus_if.bus_read, bus_if.bus_addr}, {3'b110, 5'd1});
    @(negedge clk);
    if (mid) begin req = 1'b1; scramble(); end
    chk("hold_idle1", bus_if.bus_cs, 1'b0);
    @(negedge clk);
    req = 1'b0;
    chk("hold_idle2", bus_if.bus_cs, 1'b0);
    @(negedge clk);
    chk("first_poll", {bus_if.bus_cs, bus_if.bus_write, bus_if.bus_read, bus_if.bus_addr}, {3'b101, 5'd1});
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_wait: got no done expected done within 3000 cycles");
    end
    @(negedge clk);
    chk("busy_fall", busy, 1'b0);
    chk("done_pulse", done, 1'b0);
  endtask

  task automatic reset_mid_poll();
    int n = 0;
    nack_idx = -1; stall_idx = -1; rd_dout = 8'h00;
    plan(1'b0, 7'h22, 8'h33, 8'h44, 2'd1, -1, -1, 8'h00);
    start_req(1'b0, 7'h22, 8'h33, 8'h44, 2'd1);
    while (!(bus_if.bus_cs && bus_if.bus_read) && n < 100) begin @(negedge clk); n++; end
    chk("reached_poll", bus_if.bus_cs && bus_if.bus_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_strobes", {bus_if.bus_cs, bus_if.bus_read, bus_if.bus_write}, 3'b000);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_status", {err, rdata}, 10'd0);
    exp_bus.delete();
    exp_done.delete();
    m_rdata = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic r_l;
  int   nk_l, st_l;

  initial begin
    rst = 1'b1; req = 1'b0;
    rnw = 1'b0; dev = '0; ra = '0; wd = '0; freq = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {busy, done, err, rdata, bus_if.bus_cs, bus_if.bus_read, bus_if.bus_write,
                          bus_if.bus_addr, bus_if.bus_wdata}, 64'd0);

    xfer(1'b0, 7'h50, 8'h10, 8'hA5, 2'd2, -1, -1, 8'h00, 1'b0);
    xfer(1'b1, 7'h50, 8'h10, 8'h00, 2'd1, -1, -1, 8'h3C, 1'b0);
    chk("rdata_hold", rdata, 8'h3C);
    xfer(1'b0, 7'h50, 8'h10, 8'hA5, 2'd3, 0, -1, 8'h00, 1'b0);
    xfer(1'b0, 7'h50, 8'h10, 8'hA5, 2'd0, -1, 0, 8'h00, 1'b0);
    xfer(1'b0, 7'h11, 8'h22, 8'h33, 2'd2, -1, -1, 8'h00, 1'b1);
    xfer(1'b1, 7'h12, 8'h9A, 8'h00, 2'd1, 1, -1, 8'h77, 1'b0);
    reset_mid_poll();
    xfer(1'b1, 7'h7F, 8'hFF, 8'h00, 2'd3, -1, -1, 8'hC3, 1'b0);

    for (int t = 0; t < 40; t++) begin
      r_l  = 1'($urandom);
      nk_l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      st_l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, r_l ? 6 : 4)) : -1;
      xfer(r_l, 7'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), nk_l, st_l,
           8'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_xfer_sequencer.md
# i2c_xfer_sequencer

Register-level I2C transaction engine sitting directly upstream of the memory-mapped I2C IO block. Accepts a single-byte register write or register read request and issues the complete START / address / register / data / STOP command sequence over the IO block's bus port. It polls the IO block's ready flag between commands, checks slave ACKs, and returns read data with a completion status. It also programs the SCL divider at the start of every transaction.

## Interface
- TIMEOUT, 4096: max cycles spent polling for rdy on one command before abort.
- HOLD, 2: cycles waited after each command write before rdy polling starts.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  start pulse; sampled only when busy=0.
- rnw  in  1  1 = register read, 0 = register write.
- dev_addr  in  7  7-bit slave address.
- reg_addr  in  8  slave register index.
- wdata  in  8  write byte (ignored when rnw=1).
- freq  in  2  SCL divider select.
- busy  out  1  high from the cycle after req acceptance until the cycle after done.
- done  out  1  one-cycle completion pulse.
- err_code  out  2  valid with done and held until next req: 0 ok, 1 NACK on device address, 2 NACK on register/data byte, 3 timeout.
- rdata  out  8  read byte; updated only on successful read.
- bus_cs, bus_read, bus_write  out  1 each  IO block strobes.
- bus_addr  out  5  0 = divider register, 1 = command/data register.
- bus_wdata  out  32  [10:8] cmd, [7:0] din; [1:0] = divider when bus_addr=0.
- bus_rdata  in  32  [9] ack (0 = slave ACKed), [8] rdy, [7:0] dout.

## Operation
- Command codes on bus_wdata[10:8]: START=0, WR=1, RD=2, STOP=3, RESTART=4.
- Write sequence: START; WR {dev_addr,0}; WR reg_addr; WR wdata; STOP.
- Read sequence: START; WR {dev_addr,0}; WR reg_addr; RESTART; WR {dev_addr,1}; RD with din=0x01 (NACK, last byte); STOP.
- A 3-bit step counter indexes the sequence. All request fields are latched on acceptance, so later input changes have no effect.
- States:
  - IDLE: on req, latch fields and go to SET_FREQ.
  - SET_FREQ: one-cycle bus write, addr 0, wdata[1:0]=freq; go to ISSUE.
  - ISSUE: one-cycle bus write, addr 1, current step's command; go to HOLD.
  - HOLD: HOLD cycles with bus idle; go to POLL.
  - POLL: cs=1, read=1, addr=1 each cycle until rdy=1. On rdy=1:
    - After WR, ack=1 sets err_code to 1 (address steps) or 2 (reg/data steps) and jumps to the STOP step.
    - After RD, dout is captured into rdata.
    - Otherwise advance to the next step. Completion of STOP goes to DONE.
  - Timeout: a poll counter resets on entry to POLL. Reaching TIMEOUT sets err_code=3 and goes directly to DONE, with no STOP issued.
  - DONE: done=1 for one cycle; go to IDLE.
- No ACK check is made after START, RESTART, RD or STOP.
- req while busy=1 is ignored and not queued.
- Outside write/poll cycles, bus_cs, bus_read and bus_write are 0, and bus_addr/bus_wdata hold their last values.

## Timing
- Reset: all outputs 0, state IDLE, step 0. Reset mid-transaction drops all bus strobes immediately (asynchronous); no STOP is issued.
- req at cycle 0: busy=1 and SET_FREQ write at cycle 1, first ISSUE at cycle 2, HOLD at cycles 3-4, first poll at cycle 5.
- Each command costs 1 + HOLD + N cycles, where N ≥ 1 is the number of poll cycles through the one with rdy=1.
- done is asserted the cycle after the final rdy=1 (or after the timeout cycle). busy falls on the cycle after done.
- A new req is accepted in the cycle busy=0 is first observed.
- The IO block guarantees rdy deasserts within 1 cycle of an accepted command write. HOLD must be ≥ 2.

## Test plan
- Write dev 0x50, reg 0x10, data 0xA5, freq 2, model ACKs all bytes: addr 0 write of 2, then commands 0x000, 0x1A0, 0x110, 0x1A5, 0x300; done with err_code 0; rdata unchanged.
- Read dev 0x50, reg 0x10, model returns 0x3C: commands 0x000, 0x1A0, 0x110, 0x400, 0x1A1, 0x201, 0x300; rdata=0x3C; err_code 0.
- Model NACKs the device address on a write: after the first WR, the next command is STOP (0x300); err_code=1; no data byte issued.
- Model holds rdy=0 forever with TIMEOUT=16: done exactly 16 poll cycles after the first poll; err_code=3; no STOP issued.
- Second req pulsed mid-transaction: ignored; exactly one done; subsequent req accepted normally.
- rst asserted during POLL: strobes 0 in the same cycle, busy=0, done=0; next req starts at SET_FREQ.
